// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared tone codes, sequencer state encoding and timer width
package simon_pkg;

  localparam int TONE_W  = 3;
  localparam int TIMER_W = 24;

  localparam logic [TONE_W-1:0] TONE_0 = 3'd0;
  localparam logic [TONE_W-1:0] TONE_1 = 3'd1;
  localparam logic [TONE_W-1:0] TONE_2 = 3'd2;
  localparam logic [TONE_W-1:0] TONE_3 = 3'd3;
  localparam logic [TONE_W-1:0] TONE_4 = 3'd4;
  localparam logic [TONE_W-1:0] TONE_5 = 3'd5;
  localparam logic [TONE_W-1:0] TONE_6 = 3'd6;
  localparam logic [TONE_W-1:0] TONE_7 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NOTE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/tone_seq_buffer.sv
// rtl/tone_seq_buffer.sv - note storage, synchronous write and asynchronous read
module tone_seq_buffer
  import simon_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [TONE_W-1:0]        wr_tone,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [TONE_W-1:0]        rd_tone
);

  // Storage is deliberately unreset; entries beyond count are never read.
  logic [TONE_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_tone;
  end

  assign rd_tone = mem_q[rd_idx];

endmodule

// File: rtl/tone_sequencer.sv
// rtl/tone_sequencer.sv - stores a tone sequence and plays it as timed note/gap phases
// Optional TONE_SEQ_LOOP_EN adds a loop input that restarts playback after the final gap.
module tone_sequencer
  import simon_pkg::*;
#(
  parameter int NOTE_CYCLES = 12500000,
  parameter int GAP_CYCLES  = 2500000,
  parameter int DEPTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
`ifdef TONE_SEQ_LOOP_EN
  input  logic                   loop,
`endif
  input  logic                   load_valid,
  input  logic [TONE_W-1:0]      load_tone,
  output logic                   load_ready,
  input  logic                   clear,
  input  logic                   play,
  output logic [TONE_W-1:0]      tone,
  output logic                   speaker_en,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;
  localparam logic [CW-1:0]      DEPTH_C   = CW'(DEPTH);
  localparam logic [TIMER_W-1:0] NOTE_LOAD = TIMER_W'(NOTE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [IW-1:0]       index_q, index_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic                done_q, done_d;
  logic [IW-1:0]       rd_idx;
  logic [TONE_W-1:0]   rd_tone;
  logic                wr_en;
  logic                last_note;
  logic                loop_en;

`ifdef TONE_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  assign last_note = ({1'b0, index_q} + CW'(1)) >= count_q;

  // Address of the note about to start: next slot on continuation, slot 0 otherwise.
  always_comb begin
    rd_idx = '0;
    if (state_q == ST_GAP && !last_note) rd_idx = index_q + IW'(1);
  end

  tone_seq_buffer #(.DEPTH(DEPTH)) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (count_q[IW-1:0]),
    .wr_tone (load_tone),
    .rd_idx  (rd_idx),
    .rd_tone (rd_tone)
  );

  assign load_ready = !rst && (state_q == ST_IDLE) && (count_q < DEPTH_C) && !play && !clear;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    timer_d = timer_q;
    tone_d  = tone_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (play) begin
          if (count_q == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_NOTE;
            index_d = '0;
            tone_d  = rd_tone;
            timer_d = NOTE_LOAD;
          end
        end else if (load_valid && load_ready) begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      ST_NOTE: begin
        if (timer_q == '0) begin
          state_d = ST_GAP;
          timer_d = GAP_LOAD;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      ST_GAP: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (!last_note || loop_en) begin
          state_d = ST_NOTE;
          index_d = rd_idx;
          tone_d  = rd_tone;
          timer_d = NOTE_LOAD;
        end else begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      count_q <= '0;
      timer_q <= '0;
      tone_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      timer_q <= timer_d;
      tone_q  <= tone_d;
      done_q  <= done_d;
    end
  end

  assign tone       = tone_q;
  assign speaker_en = (state_q == ST_NOTE);
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign count      = count_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// tb/tb_tone_sequencer.sv - directed and randomized checks of tone_sequencer against a queue model
module tb_tone_sequencer;

  localparam int NC  = 4;
  localparam int GC  = 2;
  localparam int DEP = 4;
  localparam int PER = NC + GC;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic [2:0] load_tone;
  logic       load_ready;
  logic       clear;
  logic       play;
  logic [2:0] tone;
  logic       speaker_en;
  logic       busy;
  logic       done;
  logic [2:0] count;
`ifdef TONE_SEQ_LOOP_EN
  logic       loop;
`endif

  logic [2:0] model[$];
  logic [2:0] last_tone;
  int n_asserts = 0;
  int n_fail    = 0;

  always #5 clk = ~clk;

  tone_sequencer #(.NOTE_CYCLES(NC), .GAP_CYCLES(GC), .DEPTH(DEP)) dut (
    .clk        (clk),
    .rst        (rst),
`ifdef TONE_SEQ_LOOP_EN
    .loop       (loop),
`endif
    .load_valid (load_valid),
    .load_tone  (load_tone),
    .load_ready (load_ready),
    .clear      (clear),
    .play       (play),
    .tone       (tone),
    .speaker_en (speaker_en),
    .busy       (busy),
    .done       (done),
    .count      (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_note(input logic [2:0] t);
    bit exp_ready;
    exp_ready  = (model.size() < DEP);
    load_valid = 1'b1;
    load_tone  = t;
    #1;
    check("load_ready", 32'(load_ready), 32'(exp_ready));
    tick();
    load_valid = 1'b0;
    if (exp_ready) model.push_back(t);
    check("count_after_load", 32'(count), 32'(model.size()));
  endtask

  task automatic clear_seq();
    clear      = 1'b1;
    load_valid = 1'b1;
    load_tone  = 3'($urandom);
    #1;
    check("clear_blocks_load", 32'(load_ready), 32'd0);
    tick();
    clear      = 1'b0;
    load_valid = 1'b0;
    model.delete();
    check("count_after_clear", 32'(count), 32'd0);
  endtask

  // Expected waveform is derived from elapsed cycles: note k/PER, sounding while k%PER < NC.
  task automatic run_play(input bit inject);
    int n;
    int total;
    int inj;
    n     = model.size();
    total = n * PER;
    inj   = inject ? int'($urandom_range(0, total - 1)) : -1;
    play       = 1'b1;
    load_valid = 1'b1;
    #1;
    check("play_blocks_load", 32'(load_ready), 32'd0);
    tick();
    play       = 1'b0;
    load_valid = 1'b0;
    for (int k = 0; k < total; k++) begin
      check("busy_play", 32'(busy), 32'd1);
      check("spk_play", 32'(speaker_en), 32'((k % PER) < NC));
      check("tone_play", 32'(tone), 32'(model[k / PER]));
      check("done_play", 32'(done), 32'd0);
      if (k == inj) begin
        play       = 1'b1;
        clear      = 1'b1;
        load_valid = 1'b1;
        #1;
        check("busy_blocks_load", 32'(load_ready), 32'd0);
      end
      tick();
      play       = 1'b0;
      clear      = 1'b0;
      load_valid = 1'b0;
    end
    check("done_end", 32'(done), 32'd1);
    check("busy_end", 32'(busy), 32'd0);
    check("spk_end", 32'(speaker_en), 32'd0);
    check("tone_hold", 32'(tone), 32'(model[n - 1]));
    check("count_kept", 32'(count), 32'(n));
    tick();
    check("done_once", 32'(done), 32'd0);
    check("tone_hold_idle", 32'(tone), 32'(model[n - 1]));
  endtask

  initial begin
    rst        = 1'b1;
    load_valid = 1'b1;
    load_tone  = 3'd0;
    clear      = 1'b0;
    play       = 1'b0;
`ifdef TONE_SEQ_LOOP_EN
    loop       = 1'b0;
`endif
    tick();
    tick();
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_tone", 32'(tone), 32'd0);
    check("rst_spk", 32'(speaker_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    load_valid = 1'b0;
    rst        = 1'b0;
    tick();

    load_note(3'd3);
    load_note(3'd5);
    load_note(3'd1);
    run_play(1'b0);
    run_play(1'b0);

    clear_seq();
    for (int i = 0; i < 5; i++) load_note(3'($urandom));
    check("full_count", 32'(count), 32'd4);
    run_play(1'b1);

    clear_seq();
    play = 1'b1;
    tick();
    play = 1'b0;
    check("empty_done", 32'(done), 32'd1);
    check("empty_busy", 32'(busy), 32'd0);
    check("empty_spk", 32'(speaker_en), 32'd0);
    tick();
    check("empty_done_once", 32'(done), 32'd0);

    for (int r = 0; r < 4; r++) begin
      int n;
      clear_seq();
      n = int'($urandom_range(1, DEP));
      for (int i = 0; i < n; i++) load_note(3'($urandom));
      run_play(1'($urandom));
    end

    clear_seq();
    load_note(3'd6);
    load_note(3'd2);
    load_note(3'd4);
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int k = 0; k < PER + 1; k++) tick();
    check("pre_rst_spk", 32'(speaker_en), 32'd1);
    rst = 1'b1;
    #1;
    check("abort_spk", 32'(speaker_en), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_count", 32'(count), 32'd0);
    tick();
    rst = 1'b0;
    model.delete();
    for (int k = 0; k < 3 * PER; k++) begin
      check("abort_no_done", 32'(done), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      tick();
    end

`ifdef TONE_SEQ_LOOP_EN
    load_note(3'd2);
    load_note(3'd7);
    loop = 1'b1;
    play = 1'b1;
    tick();
    play = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 2 * PER; k++) begin
        check("loop_busy", 32'(busy), 32'd1);
        check("loop_done", 32'(done), 32'd0);
        check("loop_tone", 32'(tone), 32'(model[k / PER]));
        check("loop_spk", 32'(speaker_en), 32'((k % PER) < NC));
        if (r == 2 && k == 0) loop = 1'b0;
        tick();
      end
    end
    check("loop_end_done", 32'(done), 32'd1);
    check("loop_end_busy", 32'(busy), 32'd0);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
TONE_SEQUENCER -- requirements
Module: tone_sequencer

Interface
REQ-001 Parameter: NOTE_CYCLES, default 12500000, clk cycles a note sounds (250 ms at 50 MHz); legal range 1..2^24-1.
REQ-002 Parameter: GAP_CYCLES, default 2500000, clk cycles of silence after each note; legal range 1..2^24-1.
REQ-003 Parameter: DEPTH, default 32, maximum stored notes; power of two, 2..256.
REQ-004 Port: clk  input  1  the block's only clock; all state changes on its rising edge.
REQ-005 Port: rst  input  1  asynchronous, active-high reset.
REQ-006 Port: load_valid  input  1  tone code on load_tone is offered for append.
REQ-007 Port: load_tone  input  3  tone code 0..7, same 3-bit encoding the speaker block uses.
REQ-008 Port: load_ready  output  1  append is accepted this cycle when load_valid and load_ready are both high.
REQ-009 Port: clear  input  1  empties the stored sequence.
REQ-010 Port: play  input  1  starts playback of the stored sequence.
REQ-011 Port: tone  output  3  tone code presented to the speaker block.
REQ-012 Port: speaker_en  output  1  enable presented to the speaker block.
REQ-013 Port: busy  output  1  high while playback is in progress.
REQ-014 Port: done  output  1  one-cycle pulse when playback finishes.
REQ-015 Port: count  output  $clog2(DEPTH)+1  number of notes currently stored.

Function
REQ-016 State machine: IDLE, NOTE, GAP; busy is high exactly in NOTE and GAP.
REQ-017 load_ready = (state==IDLE) && (count<DEPTH) && !play && !clear.
REQ-018 Accepted append writes load_tone at index count; count increments on the next edge.
REQ-019 A clear sampled in IDLE sets count to 0 on the next edge; clear outside IDLE is ignored.
REQ-020 A play sampled in IDLE with count>0 starts playback: next cycle state=NOTE, index=0, tone=note[0], speaker_en=1.
REQ-021 A play sampled in IDLE with count==0 pulses done on the next cycle and stays in IDLE; speaker_en remains 0.
REQ-022 play sampled while busy is ignored.
REQ-023 NOTE lasts exactly NOTE_CYCLES cycles with speaker_en=1; it is followed by GAP, which lasts exactly GAP_CYCLES cycles with speaker_en=0.
REQ-024 After a GAP, if index<count-1 then index increments and the next NOTE begins; otherwise state returns to IDLE.
REQ-025 done is high for the first IDLE cycle after the final GAP; busy is low in that same cycle.
REQ-026 The timer is a 24-bit down-counter loaded with the phase length minus 1; the phase ends when the timer reads 0.
REQ-027 tone holds its last played value while in GAP and IDLE.
REQ-028 The stored sequence and count are preserved across playback, so replay needs only another play.
REQ-029 Total busy duration for N notes is N*(NOTE_CYCLES+GAP_CYCLES) cycles.

Reset
REQ-030 While rst is high, outputs take: state=IDLE, count=0, index=0, timer=0, tone=0, speaker_en=0, busy=0, done=0, load_ready=0.
REQ-031 rst asserted mid-playback aborts it immediately; no done pulse is produced.
REQ-032 Buffer storage contents are not reset; they are unreachable because count=0.

Configuration
REQ-033 Macro TONE_SEQ_LOOP_EN, when defined, adds input port loop (1 bit).
REQ-034 With TONE_SEQ_LOOP_EN and loop=1 sampled at the end of the final GAP, playback restarts at index 0 with no done pulse.
REQ-035 With loop=0, or when TONE_SEQ_LOOP_EN is undefined, playback ends per REQ-024/025; when undefined, no loop port exists.

Structure
REQ-036 Shared package simon_pkg holds: tone code constants TONE_0..TONE_7, the state encoding, and the timer width constant (24).
REQ-037 Sub-module tone_seq_buffer holds the note storage: DEPTH x 3 bits, synchronous write, asynchronous read by index.

Verification (NOTE_CYCLES=4, GAP_CYCLES=2, DEPTH=4)
REQ-038 Load 3,5,1 then play -> tone 3/5/1, each with speaker_en high 4 cycles then low 2 cycles; busy high 18 cycles; then done pulses 1 cycle.
REQ-039 Load 5 tones -> 4 accepted; load_ready low once count=4; the 5th is dropped; count=4.
REQ-040 play with count=0 -> done high on the next cycle only; busy and speaker_en stay 0.
REQ-041 rst pulsed 1 cycle during the 2nd NOTE -> speaker_en, busy and count go to 0 immediately; no done pulse.
REQ-042 Within a single cycle: clear with load_valid, then play with load_valid, then play during busy -> load_ready=0 in each case; clear empties count; the play during busy is ignored; sequence timing is unchanged.
REQ-043 TONE_SEQ_LOOP_EN with loop=1 and sequence 2,7 -> the 2,7,2,7 pattern repeats with no done; setting loop=0 -> done after the current final GAP.
